// File: rtl/uart_rx_deframer_if.sv
// Signal bundle between the serial line / baud generator side and the receive deframer.
interface uart_rx_deframer_if;
  logic       rx;
  logic       sample_tick;
  logic [1:0] parity_type;
  logic [7:0] raw_data;
  logic       parity_bit;
  logic       start_bit;
  logic       stop_bit;
  logic       recieved_flag;
  logic       active;

  modport master (
    output rx, sample_tick, parity_type,
    input  raw_data, parity_bit, start_bit, stop_bit, recieved_flag, active
  );

  modport slave (
    input  rx, sample_tick, parity_type,
    output raw_data, parity_bit, start_bit, stop_bit, recieved_flag, active
  );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 16x oversampled start detection, mid-cell majority vote,
// 8 data bits LSB-first, optional parity, stop bit, one-clock completion strobe.
module uart_rx_deframer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  uart_rx_deframer_if.slave bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic has_parity(input logic [1:0] pt);
    return (pt == 2'b01) || (pt == 2'b10);
  endfunction

  logic [1:0] rx_sync_q;
  logic [2:0] state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       armed_q, armed_d;
  logic [1:0] ptype_q, ptype_d;
  logic       samp7_q, samp7_d;
  logic       samp8_q, samp8_d;
  logic [7:0] shift_q, shift_d;
  logic       start_bit_q, start_bit_d;
  logic       parity_q, parity_d;
  logic [7:0] raw_data_q;
  logic       parity_bit_q;
  logic       start_out_q;
  logic       stop_out_q;
  logic       flag_q;
  logic       active_q;

  logic rx_s;
  logic vote_s;
  logic at_vote_s;
  logic at_wrap_s;
  logic done_s;

  assign rx_s      = rx_sync_q[1];
  assign vote_s    = maj3(samp7_q, samp8_q, rx_s);
  assign at_vote_s = bus.sample_tick && (tick_cnt_q == 4'd9);
  assign at_wrap_s = bus.sample_tick && (tick_cnt_q == LAST_TICK);

  // Frame sequencing: counters, sample capture and the state machine.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    armed_d     = armed_q;
    ptype_d     = ptype_q;
    samp7_d     = samp7_q;
    samp8_d     = samp8_q;
    shift_d     = shift_q;
    start_bit_d = start_bit_q;
    parity_d    = parity_q;
    done_s      = 1'b0;

    if (bus.sample_tick && (state_q != ST_IDLE)) begin
      tick_cnt_d = tick_cnt_q + 4'd1;
      samp7_d    = (tick_cnt_q == 4'd7) ? rx_s : samp7_q;
      samp8_d    = (tick_cnt_q == 4'd8) ? rx_s : samp8_q;
    end else begin
      tick_cnt_d = tick_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.sample_tick && armed_q && !rx_s) begin
          tick_cnt_d = 4'd1;
          ptype_d    = bus.parity_type;
          armed_d    = 1'b0;
          state_d    = ST_START;
        end else if (bus.sample_tick && rx_s) begin
          armed_d = 1'b1;
        end else begin
          armed_d = armed_q;
        end
      end
      // A bad start vote is kept, not aborted, so the checker can flag it.
      ST_START: begin
        if (at_vote_s) begin
          start_bit_d = vote_s;
        end else if (at_wrap_s) begin
          bit_cnt_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          start_bit_d = start_bit_q;
        end
      end
      ST_DATA: begin
        if (at_vote_s) begin
          shift_d = {vote_s, shift_q[7:1]};
        end else if (at_wrap_s) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = has_parity(ptype_q) ? ST_PARITY : ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          shift_d = shift_q;
        end
      end
      ST_PARITY: begin
        if (at_vote_s) begin
          parity_d = vote_s;
        end else if (at_wrap_s) begin
          state_d = ST_STOP;
        end else begin
          parity_d = parity_q;
        end
      end
      // Finish at mid-stop so a following start edge can be caught early.
      ST_STOP: begin
        if (at_vote_s) begin
          done_s     = 1'b1;
          tick_cnt_d = 4'd0;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        tick_cnt_d = 4'd0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // Line synchronizer and frame-sequencing state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync_q   <= 2'b11;
      state_q     <= ST_IDLE;
      tick_cnt_q  <= 4'd0;
      bit_cnt_q   <= 3'd0;
      armed_q     <= 1'b0;
      ptype_q     <= 2'b00;
      samp7_q     <= 1'b0;
      samp8_q     <= 1'b0;
      shift_q     <= 8'h00;
      start_bit_q <= 1'b0;
      parity_q    <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      rx_sync_q   <= {rx_sync_q[0], bus.rx};
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      armed_q     <= armed_d;
      ptype_q     <= ptype_d;
      samp7_q     <= samp7_d;
      samp8_q     <= samp8_d;
      shift_q     <= shift_d;
      start_bit_q <= start_bit_d;
      parity_q    <= parity_d;
      active_q    <= (state_d != ST_IDLE);
    end
  end

  // Output fields, updated only when a whole frame has been received.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      raw_data_q   <= 8'h00;
      parity_bit_q <= 1'b1;
      start_out_q  <= 1'b0;
      stop_out_q   <= 1'b1;
      flag_q       <= 1'b0;
    end else begin
      flag_q <= done_s;
      if (done_s) begin
        raw_data_q   <= shift_q;
        parity_bit_q <= has_parity(ptype_q) ? parity_q : 1'b1;
        start_out_q  <= start_bit_q;
        stop_out_q   <= vote_s;
      end else begin
        raw_data_q   <= raw_data_q;
        parity_bit_q <= parity_bit_q;
        start_out_q  <= start_out_q;
        stop_out_q   <= stop_out_q;
      end
    end
  end

  assign bus.raw_data      = raw_data_q;
  assign bus.parity_bit    = parity_bit_q;
  assign bus.start_bit     = start_out_q;
  assign bus.stop_bit      = stop_out_q;
  assign bus.recieved_flag = flag_q;
  assign bus.active        = active_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: directed frames plus random traffic,
// compared against a per-tick line model that applies the framing rules directly.
module tb_uart_rx_deframer;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       st;
    logic       sp;
    int         tick;
  } frame_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  uart_rx_deframer_if bus();

  uart_rx_deframer #(.OVERSAMPLE(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;
  int flag_cycles = 0;
  int flag_snap = 0;

  logic       line_log[$];
  logic [1:0] pt_log[$];
  logic       act_log[$];
  logic       exp_act[$];
  frame_t     obs_q[$];
  frame_t     exp_q[$];

  // Counts every clock the completion strobe is high, to catch stretched pulses.
  always @(negedge clock) begin
    if (bus.recieved_flag === 1'b1) flag_cycles <= flag_cycles + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic cell_vote(input int d, input int c);
    return maj3(line_log[d + 16*c + 7], line_log[d + 16*c + 8], line_log[d + 16*c + 9]);
  endfunction

  function automatic frame_t obs_at(input int i);
    frame_t f = '{8'h00, 1'b0, 1'b0, 1'b0, -1};
    if (i < obs_q.size()) f = obs_q[i];
    return f;
  endfunction

  // One sample tick: line value is set two-plus clocks ahead so the synchronized copy is settled.
  task automatic do_tick(input logic v, input logic [1:0] pt);
    int t;
    @(negedge clock);
    bus.rx = v;
    bus.parity_type = pt;
    bus.sample_tick = 1'b0;
    @(negedge clock);
    repeat ($urandom_range(0, 2)) @(negedge clock);
    @(negedge clock);
    bus.sample_tick = 1'b1;
    @(negedge clock);
    bus.sample_tick = 1'b0;
    t = line_log.size();
    line_log.push_back(v);
    pt_log.push_back(pt);
    act_log.push_back(bus.active);
    if (bus.recieved_flag === 1'b1)
      obs_q.push_back('{bus.raw_data, bus.parity_bit, bus.start_bit, bus.stop_bit, t});
  endtask

  task automatic idle(input logic v, input int n);
    repeat (n) do_tick(v, 2'b00);
  endtask

  // Drives a full frame cell by cell; optional glitch, parity_type switch and early cut.
  task automatic send_frame(input logic [7:0] data, input logic [1:0] pt, input logic stop_v,
                            input int glitch_t, input int sw_t, input logic [1:0] pt_new,
                            input int cut_t);
    int p = (pt == 2'b01 || pt == 2'b10) ? 1 : 0;
    logic par = (pt == 2'b01) ? ~^data : ^data;
    logic [1:0] cur_pt = pt;
    logic v;
    int c;
    for (int t = 0; t < (10 + p) * 16; t++) begin
      c = t / 16;
      if (c == 0) v = 1'b0;
      else if (c <= 8) v = data[c-1];
      else if (c == 9 && p == 1) v = par;
      else v = stop_v;
      if (t == glitch_t) v = ~v;
      if (t == sw_t) cur_pt = pt_new;
      do_tick(v, cur_pt);
      if (cut_t >= 0 && t + 1 >= cut_t) return;
    end
  endtask

  // Reference: walk the logged line one tick at a time applying the receive rules.
  task automatic run_model();
    int n = line_log.size();
    int idx = 0;
    bit armed = 1'b0;
    int d, p, e;
    frame_t f;
    exp_q.delete();
    exp_act.delete();
    for (int i = 0; i < n; i++) exp_act.push_back(1'b0);
    while (idx < n) begin
      if (armed && line_log[idx] == 1'b0) begin
        d = idx;
        p = (pt_log[d] == 2'b01 || pt_log[d] == 2'b10) ? 1 : 0;
        e = d + (9 + p) * 16 + 9;
        for (int t = d; t < e && t < n; t++) exp_act[t] = 1'b1;
        if (e >= n) break;
        f.st = cell_vote(d, 0);
        for (int b = 0; b < 8; b++) f.data[b] = cell_vote(d, b + 1);
        f.par = (p == 1) ? cell_vote(d, 9) : 1'b1;
        f.sp = cell_vote(d, 9 + p);
        f.tick = e;
        exp_q.push_back(f);
        armed = 1'b0;
        idx = e + 1;
      end else begin
        if (line_log[idx]) armed = 1'b1;
        idx++;
      end
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, ".raw_data"}, bus.raw_data, 8'h00);
    check_eq({tag, ".parity_bit"}, bus.parity_bit, 1'b1);
    check_eq({tag, ".start_bit"}, bus.start_bit, 1'b0);
    check_eq({tag, ".stop_bit"}, bus.stop_bit, 1'b1);
    check_eq({tag, ".flag"}, bus.recieved_flag, 1'b0);
    check_eq({tag, ".active"}, bus.active, 1'b0);
  endtask

  task automatic begin_seg(input string name);
    @(negedge clock);
    reset_n = 1'b0;
    bus.rx = 1'b1;
    bus.sample_tick = 1'b0;
    bus.parity_type = 2'b00;
    #1;
    check_reset({name, ".in_reset"});
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_reset({name, ".after_reset"});
    line_log.delete();
    pt_log.delete();
    act_log.delete();
    obs_q.delete();
    flag_snap = flag_cycles;
  endtask

  task automatic end_seg(input string name);
    frame_t last;
    @(negedge clock);
    run_model();
    check_eq({name, ".frames"}, obs_q.size(), exp_q.size());
    check_eq({name, ".flag_cycles"}, flag_cycles - flag_snap, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check_eq({name, ".data"}, obs_q[i].data, exp_q[i].data);
      check_eq({name, ".parity"}, obs_q[i].par, exp_q[i].par);
      check_eq({name, ".start"}, obs_q[i].st, exp_q[i].st);
      check_eq({name, ".stop"}, obs_q[i].sp, exp_q[i].sp);
      check_eq({name, ".flag_tick"}, obs_q[i].tick, exp_q[i].tick);
    end
    for (int t = 0; t < act_log.size(); t++)
      check_eq({name, ".active"}, act_log[t], exp_act[t]);
    last = '{8'h00, 1'b1, 1'b0, 1'b1, 0};
    if (exp_q.size() > 0) last = exp_q[exp_q.size() - 1];
    check_eq({name, ".hold_data"}, bus.raw_data, last.data);
    check_eq({name, ".hold_parity"}, bus.parity_bit, last.par);
    check_eq({name, ".hold_start"}, bus.start_bit, last.st);
    check_eq({name, ".hold_stop"}, bus.stop_bit, last.sp);
  endtask

  initial begin
    frame_t f;
    bus.rx = 1'b1;
    bus.sample_tick = 1'b0;
    bus.parity_type = 2'b00;

    begin_seg("a5_even");
    idle(1'b1, 4);
    send_frame(8'hA5, 2'b10, 1'b1, -1, -1, 2'b00, -1);
    idle(1'b1, 20);
    end_seg("a5_even");
    f = obs_at(0);
    check_eq("a5.data", f.data, 8'hA5);
    check_eq("a5.parity", f.par, 1'b0);
    check_eq("a5.start", f.st, 1'b0);
    check_eq("a5.stop", f.sp, 1'b1);
    check_eq("a5.latency", f.tick, 4 + 16*10 + 9);

    begin_seg("b2b");
    idle(1'b1, 4);
    send_frame(8'h3C, 2'b00, 1'b1, -1, -1, 2'b00, -1);
    send_frame(8'hC3, 2'b00, 1'b1, -1, -1, 2'b00, -1);
    idle(1'b1, 20);
    end_seg("b2b");
    check_eq("b2b.count", obs_q.size(), 2);
    f = obs_at(0);
    check_eq("b2b.data0", f.data, 8'h3C);
    check_eq("b2b.par0", f.par, 1'b1);
    f = obs_at(1);
    check_eq("b2b.data1", f.data, 8'hC3);
    check_eq("b2b.par1", f.par, 1'b1);

    begin_seg("glitch");
    idle(1'b1, 4);
    send_frame(8'h55, 2'b01, 1'b1, 16 + 8, -1, 2'b00, -1);
    idle(1'b1, 20);
    end_seg("glitch");
    f = obs_at(0);
    check_eq("glitch.data", f.data, 8'h55);
    check_eq("glitch.parity", f.par, 1'b1);

    begin_seg("break");
    idle(1'b1, 4);
    send_frame(8'h5A, 2'b00, 1'b0, -1, -1, 2'b00, -1);
    idle(1'b0, 40 * 16);
    idle(1'b1, 32);
    send_frame(8'h96, 2'b00, 1'b1, -1, -1, 2'b00, -1);
    idle(1'b1, 20);
    end_seg("break");
    check_eq("break.count", obs_q.size(), 2);
    f = obs_at(0);
    check_eq("break.stop0", f.sp, 1'b0);
    f = obs_at(1);
    check_eq("break.data1", f.data, 8'h96);
    check_eq("break.tick1", f.tick, 4 + 160 + 640 + 32 + 153);

    begin_seg("pre_reset");
    idle(1'b1, 4);
    send_frame(8'h6E, 2'b10, 1'b1, -1, -1, 2'b00, -1);
    idle(1'b1, 5);
    send_frame(8'hFF, 2'b01, 1'b1, -1, -1, 2'b00, 5*16 + 8);
    end_seg("pre_reset");
    check_eq("pre_reset.active", bus.active, 1'b1);
    begin_seg("post_reset");
    idle(1'b1, 4);
    send_frame(8'h81, 2'b00, 1'b1, -1, -1, 2'b00, -1);
    idle(1'b1, 10);
    end_seg("post_reset");
    f = obs_at(0);
    check_eq("post_reset.data", f.data, 8'h81);

    begin_seg("ptype_switch");
    idle(1'b1, 4);
    send_frame(8'hB7, 2'b10, 1'b1, -1, 3*16 + 4, 2'b00, -1);
    idle(1'b1, 20);
    end_seg("ptype_switch");
    f = obs_at(0);
    check_eq("ptype_switch.parity", f.par, 1'b0);
    check_eq("ptype_switch.tick", f.tick, 4 + 16*10 + 9);

    begin_seg("random");
    for (int k = 0; k < 12; k++) begin
      idle(1'b1, $urandom_range(0, 12));
      send_frame(8'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 1) ? $urandom_range(0, 159) : -1,
                 -1, 2'b00, -1);
    end
    idle(1'b1, 20);
    end_seg("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Receive-side front end of the UART. It oversamples the serial line 16x, detects the start edge and majority-votes each bit at mid-cell. It shifts in 8 data bits LSB-first, plus an optional parity bit and the stop bit, then presents the captured frame fields to the receive error checker with a one-clock `recieved_flag` strobe. It sits between the baud generator (which supplies `sample_tick`) and the error checker and receive buffer.

## Interface
Parameters:
- OVERSAMPLE, 16, sample ticks per bit cell. Fixed; the counter is 4 bits.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- rx  in  1  asynchronous serial line; idle high.
- sample_tick  in  1  one-clock enable at 16x the baud rate, from the baud generator.
- parity_type  in  2  01 = odd, 10 = even, 00/11 = no parity.
- raw_data  out  8  captured data byte, bit 0 = first received.
- parity_bit  out  1  captured parity bit; forced 1 in no-parity frames.
- start_bit  out  1  voted start-bit value; 0 is correct.
- stop_bit  out  1  voted stop-bit value; 1 is correct.
- recieved_flag  out  1  one-clock strobe; frame fields valid and stable.
- active  out  1  high while a frame is in progress (any state but IDLE).

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`), reset to 1. All decisions use `rx_s`.
- All state advances occur only on clocks with `sample_tick`=1. `tick_cnt` (4 bits) counts 0..15 within a cell and wraps 15→0 at a cell boundary.
- Each bit value is the majority of `rx_s` at `tick_cnt` 7, 8 and 9. The vote is resolved at count 9.
- `armed` flag: set in IDLE on any tick with `rx_s`=1. Cleared on start detection.
- FSM:
  - IDLE: on a tick with `armed`=1 and `rx_s`=0: `tick_cnt`←1, latch `parity_type` into `ptype_q`, go to START.
  - START: at count 9, store the vote as `start_bit_q`. At the 15→0 wrap, go to DATA with `bit_cnt`=0. The frame continues even if the vote is 1, so the checker reports the start error.
  - DATA: at count 9, right-shift the vote into `shift[7]`. At the wrap, `bit_cnt`++. After the wrap with `bit_cnt`=7, go to PARITY if `ptype_q` is 01/10, else STOP.
  - PARITY: at count 9, store the vote. At the wrap, go to STOP.
  - STOP: at count 9, register the outputs and assert `recieved_flag`, then go to IDLE with `tick_cnt`←0. The remaining half of the stop cell is not waited for, which allows resync on back-to-back frames.
- Output register on frame completion:
  - `raw_data`←`shift`.
  - `parity_bit`←parity vote, or 1 in no-parity frames.
  - `start_bit`←`start_bit_q`.
  - `stop_bit`←stop vote.
- Outputs hold until the next frame completes. A partially received frame never alters them.
- `parity_type` changes mid-frame are ignored; `ptype_q` governs the frame.

## Timing
- Reset values:
  - `raw_data`=8'h00, `parity_bit`=1, `start_bit`=0, `stop_bit`=1, `recieved_flag`=0, `active`=0.
  - FSM=IDLE, `armed`=0, counters=0, `rx_s`=11.
- `rx` to `rx_s` latency: 2 clocks.
- `recieved_flag` is high for exactly the clock after the STOP count-9 tick edge. Fields are valid in that same cycle.
- Frame length from the detect tick to the flag: (1+8+P)·16 + 10 ticks, with P=1 for parity and 0 otherwise.
- Framing error case (stop vote 0 and line held low): IDLE does not re-detect until `rx_s` is seen high on a tick (`armed` rule). A break condition yields exactly one frame.
- `sample_tick` deasserted: state freezes; nothing advances.
- `reset_n` asserted mid-frame: immediate return to reset values. No `recieved_flag` is emitted, and the frame is discarded.
- `active` = state≠IDLE, registered with the state.

## Test plan
- 0xA5, even parity (parity_type=10), correct frame → raw_data=8'hA5, parity_bit=0, start_bit=0, stop_bit=1, one `recieved_flag` pulse after 16·10+10 ticks.
- 0x3C, no parity (00), then 0xC3 sent back-to-back with no idle gap → two pulses; parity_bit=1 in both; raw_data 8'h3C then 8'hC3.
- 0x55 odd parity with a 1-tick low glitch at count 8 of data bit 0 → majority vote rejects the glitch; raw_data=8'h55.
- Stop bit driven 0 and line held low for 40 cells → exactly one `recieved_flag`, stop_bit=0. Nothing further until the line returns high and a new start edge arrives.
- Reset pulse during data bit 4 → outputs return to reset values with no pulse. The following clean 0x81 frame is received correctly.
- parity_type switched 10→00 during data bit 2 → frame still includes the parity cell; the captured parity bit is reported.
